// File: rtl/counter_pkg.sv
// counter_pkg
// Shared constants and types for the cascaded byte-stage counter.
// BYTE_W              width of one counter stage
// NUM_STAGES          number of cascaded stages in the chain
// CNT_W               width of the full chain (BYTE_W * NUM_STAGES)
// byte_t              one stage's count value
// RESET_VALUE_DEFAULT value the chain loads on reset unless overridden
package counter_pkg;

    localparam int BYTE_W     = 8;
    localparam int NUM_STAGES = 4;
    localparam int CNT_W      = BYTE_W * NUM_STAGES;

    typedef logic [BYTE_W-1:0] byte_t;

    localparam logic [CNT_W-1:0] RESET_VALUE_DEFAULT = 32'h0000_0000;

endpackage : counter_pkg

// File: rtl/counter_byte_stage.sv
// counter_byte_stage
// One 8-bit slice of the cascaded counter. The slice advances by one on a
// clock edge only when its carry-in is high, and it reports a carry-out
// whenever it is about to roll over from all-ones.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset, loads reset_value
//   reset_value  value this slice takes on reset
//   carry_in     increment request from the lower slices
//   count        registered slice value
//   carry_out    carry_in AND (count == all-ones), combinational
module counter_byte_stage
    import counter_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  byte_t reset_value,
    input  logic  carry_in,
    output byte_t count,
    output logic  carry_out
);

    byte_t count_q;
    byte_t count_d;

    // Next value for this slice: hold unless every lower slice is about to
    // wrap, in which case step by one. Rolling past all-ones back to zero
    // is the natural modulo behaviour of the adder.
    always_comb begin
        count_d = count_q;
        if (carry_in) begin
            count_d = count_q + byte_t'(1);
        end
    end

    // Slice register. Reset has priority over any pending increment, so a
    // reset on the same edge as a wrap leaves the slice at its reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= reset_value;
        end else begin
            count_q <= count_d;
        end
    end

    // The carry is formed from the current register value, so the chain of
    // carries across slices is a short AND chain rather than an adder ripple.
    assign count     = count_q;
    assign carry_out = carry_in & (count_q == {BYTE_W{1'b1}});

endmodule : counter_byte_stage

// File: rtl/eight_bit_counter.sv
// eight_bit_counter
// Free-running 32-bit up-counter built from four cascaded byte slices. The
// low slice is also exported on its own as the 8-bit count, so both outputs
// always agree on the low byte.
// Parameters:
//   RESET_VALUE  value loaded into the full chain on reset
// Ports:
//   CLK          rising-edge clock
//   RESET        synchronous active-high reset, priority over counting
//   COUNT        registered low byte of the chain
//   COUNT_32BIT  registered full chain value
module eight_bit_counter
    import counter_pkg::*;
#(
    parameter logic [CNT_W-1:0] RESET_VALUE = RESET_VALUE_DEFAULT
)
(
    input  logic               CLK,
    input  logic               RESET,
    output logic [BYTE_W-1:0]  COUNT,
    output logic [CNT_W-1:0]   COUNT_32BIT
);

    logic  [NUM_STAGES:0] carry_chain;
    byte_t                stage_count [NUM_STAGES];
    logic                 wrap_carry_unused;

    // The lowest slice always counts, so its carry-in is tied high.
    assign carry_chain[0] = 1'b1;

    // Four slices, each fed by the carry of the one below it. Every slice
    // gets its own byte of the reset value and drives its own byte of the
    // wide output.
    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        counter_byte_stage u_stage (
            .clk         (CLK),
            .reset       (RESET),
            .reset_value (RESET_VALUE[g*BYTE_W +: BYTE_W]),
            .carry_in    (carry_chain[g]),
            .count       (stage_count[g]),
            .carry_out   (carry_chain[g+1])
        );

        assign COUNT_32BIT[g*BYTE_W +: BYTE_W] = stage_count[g];
    end

    // The top slice's carry marks a full 32-bit wrap; the counter wraps
    // silently, so nothing consumes it.
    assign wrap_carry_unused = carry_chain[NUM_STAGES];

    // The narrow output is the very same low-slice register, not a copy.
    assign COUNT = stage_count[0];

endmodule : eight_bit_counter

// File: tb/tb_eight_bit_counter.sv
// tb_eight_bit_counter
// Bench for eight_bit_counter. Four instances with different reset values
// share one clock and reset. The expected value of every instance is its
// reset value plus the number of non-reset edges since the last reset edge,
// taken modulo 2^32.
module tb_eight_bit_counter;

    import counter_pkg::*;

    localparam int               NUM_DUT = 4;
    localparam logic [31:0]      RV_B    = 32'h00FF_FFFE;
    localparam logic [31:0]      RV_C    = 32'hFFFF_FFFF;
    localparam logic [31:0]      RV_D    = 32'h12FE_FFF0;
    localparam logic [31:0]      RV_TAB [NUM_DUT] = '{32'h0000_0000, RV_B, RV_C, RV_D};

    logic        clk_tb;
    logic        reset_tb;
    logic [7:0]  count8  [NUM_DUT];
    logic [31:0] count32 [NUM_DUT];

    int unsigned edges_since_reset;
    int          check_count;
    int          error_count;

    eight_bit_counter u_dut_a (
        .CLK         (clk_tb),
        .RESET       (reset_tb),
        .COUNT       (count8[0]),
        .COUNT_32BIT (count32[0])
    );

    eight_bit_counter #(.RESET_VALUE(RV_B)) u_dut_b (
        .CLK         (clk_tb),
        .RESET       (reset_tb),
        .COUNT       (count8[1]),
        .COUNT_32BIT (count32[1])
    );

    eight_bit_counter #(.RESET_VALUE(RV_C)) u_dut_c (
        .CLK         (clk_tb),
        .RESET       (reset_tb),
        .COUNT       (count8[2]),
        .COUNT_32BIT (count32[2])
    );

    eight_bit_counter #(.RESET_VALUE(RV_D)) u_dut_d (
        .CLK         (clk_tb),
        .RESET       (reset_tb),
        .COUNT       (count8[3]),
        .COUNT_32BIT (count32[3])
    );

    // 10 ns clock period.
    initial begin
        clk_tb = 1'b0;
        forever #5 clk_tb = ~clk_tb;
    end

    // Reference model: count the edges seen since the last reset edge.
    always @(posedge clk_tb) begin
        if (reset_tb) begin
            edges_since_reset <= 0;
        end else begin
            edges_since_reset <= edges_since_reset + 1;
        end
    end

    // Single comparison point; counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Compare every instance against the model.
    task automatic checkAll(input string tag);
        logic [31:0] expected;
        for (int i = 0; i < NUM_DUT; i++) begin
            expected = RV_TAB[i] + 32'(edges_since_reset);
            checkOutput($sformatf("%s_dut%0d_count32", tag, i), count32[i], expected);
            checkOutput($sformatf("%s_dut%0d_count8", tag, i), {24'h0, count8[i]},
                        {24'h0, expected[7:0]});
        end
    endtask

    // Drive reset for a number of edges, checking every instance after each.
    task automatic applyStimulus(input logic rst, input int edges, input string tag);
        for (int i = 0; i < edges; i++) begin
            reset_tb = rst;
            @(negedge clk_tb);
            checkAll(tag);
        end
    endtask

    initial begin
        int run_len;
        check_count = 0;
        error_count = 0;
        reset_tb    = 1'b1;

        // Reset held over two edges: everything sits at its reset value.
        applyStimulus(1'b1, 2, "reset");
        checkOutput("reset_count32", count32[0], 32'h0000_0000);
        checkOutput("reset_count8", {24'h0, count8[0]}, 32'h0);
        checkOutput("reset_rv_b", count32[1], 32'h00FF_FFFE);

        // First edges after reset: 32-bit wrap and multi-stage carry.
        applyStimulus(1'b0, 1, "first");
        checkOutput("wrap32_count32", count32[2], 32'h0000_0000);
        checkOutput("wrap32_count8", {24'h0, count8[2]}, 32'h0);
        applyStimulus(1'b0, 1, "second");
        checkOutput("carry3_count32", count32[1], 32'h0100_0000);
        checkOutput("carry3_count8", {24'h0, count8[1]}, 32'h0);

        // Basic count of ten from reset.
        applyStimulus(1'b1, 1, "reset");
        applyStimulus(1'b0, 10, "basic");
        checkOutput("count10_count32", count32[0], 32'd10);
        checkOutput("count10_count8", {24'h0, count8[0]}, 32'd10);

        // 8-bit wrap after 256 edges from reset.
        applyStimulus(1'b1, 1, "reset");
        applyStimulus(1'b0, 255, "run");
        checkOutput("pre_wrap8_count32", count32[0], 32'h0000_00FF);
        checkOutput("pre_wrap8_count8", {24'h0, count8[0]}, 32'h0000_00FF);
        applyStimulus(1'b0, 1, "wrap8");
        checkOutput("wrap8_count32", count32[0], 32'h0000_0100);
        checkOutput("wrap8_count8", {24'h0, count8[0]}, 32'h0);

        // Reset pulse at 8'h37, then exactly at 8'hFF.
        applyStimulus(1'b1, 1, "reset");
        applyStimulus(1'b0, 8'h37, "run");
        checkOutput("at_37", count32[0], 32'h0000_0037);
        applyStimulus(1'b1, 1, "mid_reset");
        checkOutput("mid_reset_count32", count32[0], 32'h0);
        applyStimulus(1'b0, 1, "after_mid");
        checkOutput("after_mid_count32", count32[0], 32'h1);
        applyStimulus(1'b0, 254, "run");
        checkOutput("at_ff", {24'h0, count8[0]}, 32'h0000_00FF);
        applyStimulus(1'b1, 1, "wrap_reset");
        checkOutput("wrap_reset_count32", count32[0], 32'h0);
        checkOutput("wrap_reset_count8", {24'h0, count8[0]}, 32'h0);
        applyStimulus(1'b0, 1, "after_wrap");
        checkOutput("after_wrap_count8", {24'h0, count8[0]}, 32'h1);

        // Randomized reset pulses and run lengths.
        for (int iter = 0; iter < 20; iter++) begin
            if ($urandom_range(0, 2) != 0) begin
                applyStimulus(1'b1, int'($urandom_range(1, 3)), "rand_reset");
            end
            run_len = int'($urandom_range(1, 300));
            applyStimulus(1'b0, run_len, "rand_run");
        end

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule : tb_eight_bit_counter

// File: doc/eight_bit_counter.md
# eight_bit_counter

Free-running synchronous up-counter providing an 8-bit count and a 32-bit extended count from a single clock. It is built as four cascaded 8-bit counter stages: the low byte is exported as `COUNT`, and the full chain is exported as `COUNT_32BIT`. It serves as a generic cycle/event counter and timebase beside the ALU datapath.

## Interface

**Parameters**
- `RESET_VALUE`, default 32'h0000_0000: value loaded into the 32-bit chain on reset. `COUNT` loads bits [7:0] of it.

**Ports**
- `CLK`, input, 1: single clock. All state updates on the rising edge.
- `RESET`, input, 1: reset, synchronous and active-high. It is sampled on the `CLK` rising edge and has priority over counting.
- `COUNT`, output, 8: current low-byte count, registered.
- `COUNT_32BIT`, output, 32: current full 32-bit count, registered.

Port order is fixed as CLK, RESET, COUNT, COUNT_32BIT, so positional instantiation is valid.

## Operation

- **Reset:** on a rising edge with `RESET`=1, the chain loads `RESET_VALUE`. With the default, `COUNT`=8'h00 and `COUNT_32BIT`=32'h0000_0000.
- **Count:** on a rising edge with `RESET`=0, the chain increments by exactly 1. There is no enable, load or direction control.
- **Stage behaviour:**
  - Stage 0 has carry-in tied to 1.
  - Stage n increments only when every lower stage is 8'hFF, via ripple-free carry: carry-out = carry-in AND (stage == 8'hFF).
- **Invariant:** `COUNT` == `COUNT_32BIT[7:0]` at all times. Both come from the same stage-0 register, not a separate counter.
- **8-bit wrap:**
  - `COUNT` goes 8'hFF -> 8'h00 with no stall or flag.
  - At the same edge, `COUNT_32BIT` goes, e.g., 32'h0000_00FF -> 32'h0000_0100.
- **32-bit wrap:** 32'hFFFF_FFFF -> 32'h0000_0000, silently.
- **Reset mid-count:** reset overrides any count value on that edge. Counting resumes from `RESET_VALUE` on the first edge after `RESET` is deasserted.
- **Simultaneous reset and wrap:** reset wins, and no increment is applied.
- **Before the first reset edge:** outputs are undefined (X in simulation). The system must assert `RESET` for at least one `CLK` edge.

## Timing

- All outputs come directly from flops, with no combinational path from inputs to outputs.
- Latency:
  - A reset asserted before edge k is visible on the outputs after edge k.
  - The first increment appears after the first edge with `RESET`=0.
- Throughput: one increment per clock.
- Carry generation is combinational across four stages, at most three AND levels. It must close timing at the system clock.

## Structure

- Sub-module `counter_byte_stage`:
  - Ports: clk, synchronous active-high reset, 8-bit reset value, carry-in, 8-bit count out, carry-out.
  - Carry-out is combinational: carry-in AND (count == 8'hFF).
- The top level instantiates four stages with a generate loop. It chains the carries and concatenates stage outputs into `COUNT_32BIT`. `COUNT` is assigned from stage 0.
- Shared package `counter_pkg` holds:
  - `BYTE_W`=8
  - `NUM_STAGES`=4
  - `CNT_W`=32
  - a byte_t typedef
  - the `RESET_VALUE` default constant
- No other typedefs are needed.

## Test plan

1. **Reset:** `RESET`=1 across two edges -> `COUNT`=8'h00 and `COUNT_32BIT`=0 after the first edge, held there.
2. **Basic count:** deassert `RESET`, run 10 edges (10 ns period) -> `COUNT`=8'd10 and `COUNT_32BIT`=32'd10; `COUNT`==`COUNT_32BIT[7:0]` on every cycle.
3. **8-bit wrap:** run 256 edges from reset -> `COUNT`=8'h00 and `COUNT_32BIT`=32'h0000_0100; one edge earlier, 8'hFF and 32'h0000_00FF.
4. **Multi-stage carry:** `RESET_VALUE`=32'h00FF_FFFE, 2 edges after reset -> 32'h0100_0000 and `COUNT`=8'h00.
5. **32-bit wrap:** `RESET_VALUE`=32'hFFFF_FFFF, one edge after reset -> `COUNT_32BIT`=0 and `COUNT`=0.
6. **Reset mid-count and at wrap:** pulse `RESET` for one edge at count 8'h37, and again exactly at 8'hFF -> both outputs 0 after that edge with no increment, then 1 on the next edge.
